// File: rtl/key_press_event.sv
// Classifies debounced active-low key presses as short or long and emits single-cycle event pulses.
// Optional feature: define KEY_REPEAT_EN to re-issue key_long every REPEAT_CNT cycles while held.
module key_press_event #(
   parameter logic [25:0] LONG_CNT   = 26'd50_000_000,
   parameter logic [25:0] REPEAT_CNT = 26'd10_000_000
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key_filter,
   output logic key_short,
   output logic key_long,
   output logic key_held
);

`ifdef KEY_REPEAT_EN
   typedef enum logic [1:0] {IDLE, PRESS, HOLD, REPEAT} state_t;
   localparam logic [25:0] REPEAT_LAST = REPEAT_CNT - 26'd1;
`else
   typedef enum logic [1:0] {IDLE, PRESS, HOLD} state_t;
`endif

   localparam logic [25:0] LONG_LAST = LONG_CNT - 26'd1;

   // Both counts must leave room for at least one counting cycle.
   if (LONG_CNT < 26'd2 || REPEAT_CNT < 26'd2) begin : g_param_check
      $error("key_press_event: LONG_CNT and REPEAT_CNT must be >= 2");
   end

   state_t      state;
   state_t      state_nxt;
   logic [25:0] cnt;
   logic [25:0] cnt_nxt;
   logic        key_d0;
   logic        fall;
   logic        rise;
   logic        short_nxt;
   logic        long_nxt;

   assign fall = key_d0 & ~key_filter;
   assign rise = ~key_d0 & key_filter;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         key_d0    <= 1'b1;
         state     <= IDLE;
         cnt       <= '0;
         key_short <= 1'b0;
         key_long  <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         key_d0    <= key_filter;
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         key_short <= short_nxt;
         key_long  <= long_nxt;
         key_held  <= (state_nxt != IDLE);
      end
   end

   // Release is checked before the terminal count so a coincident rise always wins.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      short_nxt = 1'b0;
      long_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (fall) begin
               state_nxt = PRESS;
            end
         end
         PRESS: begin
            if (rise) begin
               short_nxt = 1'b1;
               state_nxt = IDLE;
            end else if (cnt == LONG_LAST) begin
               long_nxt  = 1'b1;
`ifdef KEY_REPEAT_EN
               state_nxt = REPEAT;
`else
               state_nxt = HOLD;
`endif
            end else if (cnt != '1) begin
               cnt_nxt = cnt + 26'd1;
            end else begin
               cnt_nxt = cnt;
            end
         end
         HOLD: begin
            if (rise) begin
               state_nxt = IDLE;
            end
         end
`ifdef KEY_REPEAT_EN
         REPEAT: begin
            if (rise) begin
               state_nxt = IDLE;
            end else if (cnt == REPEAT_LAST) begin
               long_nxt = 1'b1;
            end else if (cnt != '1) begin
               cnt_nxt = cnt + 26'd1;
            end else begin
               cnt_nxt = cnt;
            end
         end
`endif
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_key_press_event.sv
// Self-checking bench for key_press_event: directed vector table, hand-written corner sequences,
// and randomized key activity checked against a press-duration reference model.
module tb_key_press_event;

   localparam logic [25:0] LONG_P = 26'd10;
   localparam logic [25:0] REP_P  = 26'd4;
   localparam int          LONG_I = 10;
   localparam int          REP_I  = 4;

   logic sys_clk = 1'b0;
   logic sys_rst_n;
   logic key_filter;
   logic key_short;
   logic key_long;
   logic key_held;

   int checks = 0;
   int errors = 0;

   key_press_event #(
      .LONG_CNT  (LONG_P),
      .REPEAT_CNT(REP_P)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_filter(key_filter),
      .key_short (key_short),
      .key_long  (key_long),
      .key_held  (key_held)
   );

   always #5 sys_clk = ~sys_clk;

   // Reference model: tracks how long the current press has lasted, in sampled clock edges.
   bit   m_prev;
   bit   m_pressing;
   bit   m_long_done;
   int   m_age;
   logic [2:0] m_exp;

   function automatic void modelReset();
      m_prev      = 1'b1;
      m_pressing  = 1'b0;
      m_long_done = 1'b0;
      m_age       = 0;
      m_exp       = 3'b000;
   endfunction

   function automatic void modelStep(input logic k);
      logic s;
      logic l;
      s = 1'b0;
      l = 1'b0;
      if (!m_pressing) begin
         if (m_prev && !k) begin
            m_pressing  = 1'b1;
            m_age       = 0;
            m_long_done = 1'b0;
         end
      end else if (k) begin
         m_pressing = 1'b0;
         s          = !m_long_done;
      end else begin
         m_age++;
         if (m_age == LONG_I) begin
            l           = 1'b1;
            m_long_done = 1'b1;
         end
`ifdef KEY_REPEAT_EN
         else if (m_age > LONG_I && ((m_age - LONG_I) % REP_I) == 0) begin
            l = 1'b1;
         end
`endif
      end
      m_prev = k;
      m_exp  = {s, l, m_pressing};
   endfunction

   typedef struct {
      logic       key;
      logic [2:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic void addVec(input logic k, input logic [2:0] e, input int n);
      vec_t v;
      v.key = k;
      v.exp = e;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endfunction

   // Inputs change on the falling edge; the model advances on the rising edge it is sampled by.
   task automatic applyStimulus(input logic k);
      key_filter = k;
      @(posedge sys_clk);
      modelStep(k);
      @(negedge sys_clk);
   endtask

   task automatic checkOutput(input string name, input logic [2:0] exp);
      checks++;
      if ({key_short, key_long, key_held} !== exp) begin
         errors++;
         $display("[TB] FAIL %s: short/long/held got=%b required=%b at %0t",
                  name, {key_short, key_long, key_held}, exp, $time);
      end
   endtask

   task automatic checkExclusive(input string name);
      checks++;
      if (key_short && key_long) begin
         errors++;
         $display("[TB] FAIL %s: short and long both high got=%b%b required=not 11 at %0t",
                  name, key_short, key_long, $time);
      end
   endtask

   int nlong;
   int exp_nlong;
   logic lvl;
   int run;

   initial begin
      sys_rst_n  = 1'b0;
      key_filter = 1'b1;
      modelReset();
      @(negedge sys_clk);
      @(negedge sys_clk);
      checkOutput("reset", 3'b000);
      sys_rst_n = 1'b1;

      // Directed table: short press, rise at cnt==LONG-1, first long, two back-to-back shorts.
      addVec(1'b1, 3'b000, 2);
      addVec(1'b0, 3'b001, 5);
      addVec(1'b1, 3'b100, 1);
      addVec(1'b1, 3'b000, 2);
      addVec(1'b0, 3'b001, 10);
      addVec(1'b1, 3'b100, 1);
      addVec(1'b1, 3'b000, 1);
      addVec(1'b0, 3'b001, 10);
      addVec(1'b0, 3'b011, 1);
      addVec(1'b0, 3'b001, 2);
      addVec(1'b1, 3'b000, 2);
      addVec(1'b0, 3'b001, 3);
      addVec(1'b1, 3'b100, 1);
      addVec(1'b1, 3'b000, 2);
      addVec(1'b0, 3'b001, 3);
      addVec(1'b1, 3'b100, 1);
      addVec(1'b1, 3'b000, 1);
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].key);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Long hold: one key_long, or periodic repeats when the repeat feature is built.
      nlong = 0;
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b0);
         checkOutput($sformatf("hold%0d", i), m_exp);
         if (key_long) nlong++;
      end
      applyStimulus(1'b1);
      checkOutput("hold_release", 3'b000);
      applyStimulus(1'b1);
      checkOutput("hold_idle", 3'b000);
`ifdef KEY_REPEAT_EN
      exp_nlong = 6;
`else
      exp_nlong = 1;
`endif
      checks++;
      if (nlong != exp_nlong) begin
         errors++;
         $display("[TB] FAIL hold_count: key_long pulses got=%0d required=%0d", nlong, exp_nlong);
      end

      // Reset mid-press at cnt==5, key kept low: a new press is timed from reset release.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0);
         checkOutput($sformatf("pre_rst%0d", i), 3'b001);
      end
      sys_rst_n = 1'b0;
      #1;
      checkOutput("rst_mid", 3'b000);
      modelReset();
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1'b0);
         checkOutput($sformatf("post_rst%0d", i), (i == 10) ? 3'b011 : 3'b001);
      end
      applyStimulus(1'b1);
      checkOutput("post_rst_release", 3'b000);

      // Randomized runs of random length against the reference model.
      lvl = 1'b1;
      for (int r = 0; r < 60; r++) begin
         lvl = ~lvl;
         run = $urandom_range(1, 18);
         for (int c = 0; c < run; c++) begin
            applyStimulus(lvl);
            checkOutput($sformatf("rand%0d_%0d", r, c), m_exp);
            checkExclusive($sformatf("excl%0d_%0d", r, c));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
